// File: rtl/imem_responder.sv
// imem_responder: word-organised on-chip RAM that answers one
// mem_in_type request at a time after a fixed latency, with a
// single-cycle mem_ready pulse. A new request may be accepted in the
// same cycle a response is delivered, so a sequential fetcher can
// stream one word per cycle when latency is 1.

package imem_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_spec;
        logic        mem_instr;
        logic [1:0]  mem_mode;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

endpackage

module imem_responder
    import imem_pkg::*;
#(
    parameter int          mem_depth = 10,     // log2 of RAM size in words
    parameter int          latency   = 1,      // request-to-ready cycles, 1..15
    parameter logic [31:0] base_addr = 32'h0   // byte address of word 0, word aligned
) (
    input  logic        rst,
    input  logic        clk,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out
);

    localparam int          words    = 2 ** mem_depth;
    localparam logic [32:0] span     = 33'(words) << 2;
    localparam logic [32:0] base_ext = {1'b0, base_addr};
    localparam logic [3:0]  lat_load = 4'(latency - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    logic [3:0] count;

    // Request fields held while the access is outstanding
    logic [mem_depth-1:0] lat_index;
    logic                 lat_in_range;
    logic [31:0]          lat_wdata;
    logic [3:0]           lat_wstrb;
    logic                 lat_fence;

    // Registered response
    logic        ready_q;
    logic [31:0] rdata_q;

    // Storage; contents survive reset
    logic [31:0] ram [words];

    // Decode of the incoming request
    logic [32:0]          addr_ext;
    logic [32:0]          offset;
    logic                 in_range;
    logic [mem_depth-1:0] in_index;
    logic                 accept;

    // Read path feeding the response register
    logic [mem_depth-1:0] rd_index;
    logic                 rd_in_range;
    logic                 rd_is_read;
    logic [31:0]          ram_word;
    logic [31:0]          merged_word;
    logic [31:0]          rd_data;
    logic                 ram_write;

    // Fields that carry no meaning for this memory are gathered here
    logic unused_bits;

    // Range check in 33 bits so addresses that wrap past the top of the
    // 32-bit space never alias back into the RAM window
    always_comb begin
        addr_ext = {1'b0, imem_in.mem_addr};
        offset   = addr_ext - base_ext;
        in_range = (addr_ext >= base_ext) && (addr_ext < (base_ext + span));
        in_index = offset[mem_depth+1:2];
        accept   = imem_in.mem_valid && ((state == IDLE) || (state == RESP));
    end

    assign unused_bits = ^{imem_in.mem_spec, imem_in.mem_instr, imem_in.mem_mode,
                           offset[32:mem_depth+2], offset[1:0]};

    // A write commits at the end of its response cycle
    assign ram_write = (state == RESP) && lat_in_range && !lat_fence && (lat_wstrb != 4'h0);

    // Pick which request is about to enter RESP: with latency 1 it is the
    // one being accepted right now, otherwise it is the latched one
    always_comb begin
        if (latency == 1) begin
            rd_index    = in_index;
            rd_in_range = in_range;
            rd_is_read  = !imem_in.mem_fence && (imem_in.mem_wstrb == 4'h0);
        end else begin
            rd_index    = lat_index;
            rd_in_range = lat_in_range;
            rd_is_read  = !lat_fence && (lat_wstrb == 4'h0);
        end
    end

    assign ram_word = ram[rd_index];

    // Forward bytes from a write committing this edge so a read accepted
    // in the write's response cycle sees the new data
    always_comb begin
        merged_word = ram_word;
        if (ram_write && (lat_index == rd_index)) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_wstrb[i]) begin
                    merged_word[8*i +: 8] = lat_wdata[8*i +: 8];
                end
            end
        end
        rd_data = (rd_in_range && rd_is_read) ? merged_word : 32'h0;
    end

    // Request sequencer: accept, count down the latency, pulse the response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= 4'h0;
            lat_index    <= '0;
            lat_in_range <= 1'b0;
            lat_wdata    <= 32'h0;
            lat_wstrb    <= 4'h0;
            lat_fence    <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        lat_index    <= in_index;
                        lat_in_range <= in_range;
                        lat_wdata    <= imem_in.mem_wdata;
                        lat_wstrb    <= imem_in.mem_wstrb;
                        lat_fence    <= imem_in.mem_fence;
                        if (latency == 1) begin
                            state   <= RESP;
                            count   <= 4'h0;
                            ready_q <= 1'b1;
                            rdata_q <= rd_data;
                        end else begin
                            state <= BUSY;
                            count <= lat_load;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (count == 4'h1) begin
                        state   <= RESP;
                        count   <= 4'h0;
                        ready_q <= 1'b1;
                        rdata_q <= rd_data;
                    end else begin
                        count <= count - 4'h1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 4'h0;
                end
            endcase
        end
    end

    // Byte-lane RAM write at the end of a write's response cycle
    always_ff @(posedge clk) begin
        if (ram_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_wstrb[i]) begin
                    ram[lat_index][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    assign imem_out.mem_ready = ready_q;
    assign imem_out.mem_rdata = rdata_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed test of imem_responder at latencies 3, 1
// and 4, with hand-computed responses for each request.

module tb_imem_responder;

    import imem_pkg::*;

    logic        clk;
    logic        rst [3];
    mem_in_type  req [3];
    mem_out_type rsp [3];

    int assertCount = 0;
    int failCount   = 0;

    // Instance 0: latency 3 for the general and boundary tests
    imem_responder #(.mem_depth(10), .latency(3), .base_addr(32'h0)) dut_lat3 (
        .rst      (rst[0]),
        .clk      (clk),
        .imem_in  (req[0]),
        .imem_out (rsp[0])
    );

    // Instance 1: latency 1 for streaming and same-cycle forwarding
    imem_responder #(.mem_depth(10), .latency(1), .base_addr(32'h0)) dut_lat1 (
        .rst      (rst[1]),
        .clk      (clk),
        .imem_in  (req[1]),
        .imem_out (rsp[1])
    );

    // Instance 2: latency 4 for the mid-request reset
    imem_responder #(.mem_depth(10), .latency(4), .base_addr(32'h0)) dut_lat4 (
        .rst      (rst[2]),
        .clk      (clk),
        .imem_in  (req[2]),
        .imem_out (rsp[2])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls far beyond any expected run time
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drop the request and confirm the responder stays quiet for n cycles
    task automatic idleCycles(input int dut, input string tag, input int n);
        req[dut] = '0;
        repeat (n) begin
            @(negedge clk);
            checkOutput({tag, "_ready"}, 32'(rsp[dut].mem_ready), 32'h0);
            checkOutput({tag, "_rdata"}, rsp[dut].mem_rdata, 32'h0);
        end
    endtask

    // Present one request starting this cycle and wait for its response.
    // Returns in the ready cycle with the request still driven, so the
    // caller either presents the next request or idles right away.
    task automatic applyStimulus(input int dut, input string tag, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic fence, input int expLatency,
                                 input logic [31:0] expData, input bit dropValid);
        int waited;
        bit seen;
        req[dut].mem_valid = 1'b1;
        req[dut].mem_fence = fence;
        req[dut].mem_spec  = 1'b0;
        req[dut].mem_instr = 1'b1;
        req[dut].mem_mode  = 2'b11;
        req[dut].mem_addr  = addr;
        req[dut].mem_wdata = wdata;
        req[dut].mem_wstrb = wstrb;
        waited = 0;
        seen   = 1'b0;
        while (!seen && (waited < expLatency + 6)) begin
            @(negedge clk);
            waited++;
            if (dropValid) req[dut].mem_valid = 1'b0;
            if (rsp[dut].mem_ready) seen = 1'b1;
            else checkOutput({tag, "_wait_rdata"}, rsp[dut].mem_rdata, 32'h0);
        end
        checkOutput({tag, "_ready_seen"}, 32'(seen), 32'h1);
        checkOutput({tag, "_latency"}, 32'(waited), 32'(expLatency));
        checkOutput({tag, "_rdata"}, rsp[dut].mem_rdata, expData);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            req[i] = '0;
        end

        // Reset held, then released with no requests
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("reset%0d_ready", i), 32'(rsp[i].mem_ready), 32'h0);
                checkOutput($sformatf("reset%0d_rdata", i), rsp[i].mem_rdata, 32'h0);
            end
        end
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("idle%0d_ready", i), 32'(rsp[i].mem_ready), 32'h0);
                checkOutput($sformatf("idle%0d_rdata", i), rsp[i].mem_rdata, 32'h0);
            end
        end

        // Latency 3: write then read, next request in the ready cycle
        applyStimulus(0, "wr_10",       32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 3, 32'h0,        1'b0);
        applyStimulus(0, "rd_10",       32'h10,  32'h0,        4'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0);
        applyStimulus(0, "rd_13_unal",  32'h13,  32'h0,        4'h0, 1'b0, 3, 32'hDEADBEEF, 1'b0);

        // Byte strobes: lanes 0 and 2 replaced, lanes 1 and 3 kept
        applyStimulus(0, "wr_20_full",  32'h20,  32'h11223344, 4'hF, 1'b0, 3, 32'h0,        1'b0);
        applyStimulus(0, "wr_20_strb",  32'h20,  32'hAABBCCDD, 4'h5, 1'b0, 3, 32'h0,        1'b0);
        applyStimulus(0, "rd_20",       32'h20,  32'h0,        4'h0, 1'b0, 3, 32'h11BB33DD, 1'b0);

        // Top word of the window and the first word past it
        applyStimulus(0, "wr_ffc",      32'hFFC, 32'h5A5A0FFC, 4'hF, 1'b0, 3, 32'h0,        1'b0);
        applyStimulus(0, "rd_ffc",      32'hFFC, 32'h0,        4'h0, 1'b0, 3, 32'h5A5A0FFC, 1'b0);
        applyStimulus(0, "wr_0",        32'h0,   32'h00000077, 4'hF, 1'b0, 3, 32'h0,        1'b0);
        applyStimulus(0, "wr_1000_oor", 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 3, 32'h0,       1'b0);
        applyStimulus(0, "rd_1000_oor", 32'h1000, 32'h0,       4'h0, 1'b0, 3, 32'h0,        1'b0);
        applyStimulus(0, "rd_0",        32'h0,   32'h0,        4'h0, 1'b0, 3, 32'h00000077, 1'b0);
        applyStimulus(0, "rd_wrap_oor", 32'hFFFFFFFC, 32'h0,   4'h0, 1'b0, 3, 32'h0,        1'b0);

        // Fence wins over strobes and leaves the word alone
        applyStimulus(0, "fence_10",    32'h10,  32'h0,        4'hF, 1'b1, 3, 32'h0,        1'b0);
        applyStimulus(0, "rd_10_post",  32'h10,  32'h0,        4'h0, 1'b0, 3, 32'hDEADBEEF, 1'b1);
        idleCycles(0, "lat3_tail", 3);

        // Latency 1: preload words 0..7, then stream them back
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, $sformatf("preload%0d", k), 32'(k * 4), 32'(k), 4'hF, 1'b0, 1, 32'h0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, $sformatf("stream%0d", k), 32'(k * 4), 32'h0, 4'h0, 1'b0, 1, 32'(k), 1'b0);
        end

        // Latency 1: read accepted in a write's ready cycle sees the write
        applyStimulus(1, "wr_100",      32'h100, 32'h13579BDF, 4'hF, 1'b0, 1, 32'h0,        1'b0);
        applyStimulus(1, "rd_100_fwd",  32'h100, 32'h0,        4'h0, 1'b0, 1, 32'h13579BDF, 1'b0);
        applyStimulus(1, "wr_104_full", 32'h104, 32'h01020304, 4'hF, 1'b0, 1, 32'h0,        1'b0);
        applyStimulus(1, "wr_104_top",  32'h104, 32'hFF000000, 4'h8, 1'b0, 1, 32'h0,        1'b0);
        applyStimulus(1, "rd_104_fwd",  32'h104, 32'h0,        4'h0, 1'b0, 1, 32'hFF020304, 1'b0);
        idleCycles(1, "lat1_tail", 2);

        // Latency 4: known value, then a write aborted by reset in cycle 2
        applyStimulus(2, "wr_40_known", 32'h40,  32'hCAFEF00D, 4'hF, 1'b0, 4, 32'h0,        1'b0);
        idleCycles(2, "lat4_gap", 2);
        req[2].mem_valid = 1'b1;
        req[2].mem_addr  = 32'h40;
        req[2].mem_wdata = 32'h12345678;
        req[2].mem_wstrb = 4'hF;
        @(negedge clk);
        checkOutput("abort_c1_ready", 32'(rsp[2].mem_ready), 32'h0);
        @(negedge clk);
        checkOutput("abort_c2_ready", 32'(rsp[2].mem_ready), 32'h0);
        #2;
        rst[2] = 1'b0;
        req[2] = '0;
        #1;
        checkOutput("abort_async_ready", 32'(rsp[2].mem_ready), 32'h0);
        repeat (3) @(negedge clk);
        rst[2] = 1'b1;
        idleCycles(2, "abort_quiet", 6);
        applyStimulus(2, "rd_40_after", 32'h40,  32'h0,        4'h0, 1'b0, 4, 32'hCAFEF00D, 1'b0);
        idleCycles(2, "lat4_tail", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
